// File: rtl/aoi_sweep_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// aoi_sweep_ctrl
//   Self-test sequencer for a 4-input AND-OR gate block
//   (out = (a&b)|(c&d), out_n = ~out). A start pulse in IDLE launches a sweep
//   over all 16 input vectors in ascending order. Each vector is held for
//   SETTLE_CYCLES cycles plus one check cycle. The gate response is then
//   compared against the golden function. Pass/fail, a saturating mismatch
//   count and the first failing vector are reported.
//
// Parameters
//   SETTLE_CYCLES : cycles each vector is held before sampling (1..15)
//   ERR_W         : width of err_count (saturates at 2^ERR_W-1)
//
// Ports
//   clk              in   rising-edge clock
//   rst_n            in   asynchronous active-low reset
//   start            in   sweep request, sampled only in IDLE
//   out_in           in   out from the gate block
//   out_n_in         in   out_n from the gate block
//   a,b,c,d          out  registered test vector bits 3..0
//   busy             out  high while in SETTLE/CHECK
//   done             out  one-cycle pulse at sweep end
//   pass             out  last sweep ended with err_count==0
//   err_count        out  mismatching vectors in the last sweep
//   first_fail_vec   out  {a,b,c,d} of the first mismatch
//   first_fail_valid out  first_fail_vec holds a real vector
//
// Build option
//   AOI_SWEEP_STOP_ON_FAIL_EN : when defined, the first mismatch ends the
//   sweep immediately, leaving a..d on the failing vector.
// -----------------------------------------------------------------------------
module aoi_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             out_in,
    input  logic             out_n_in,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       first_fail_vec,
    output logic             first_fail_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    // Counter runs from 0; the last settle cycle is the one where it reads
    // SETTLE_CYCLES-1, so the vector is held exactly SETTLE_CYCLES cycles.
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;
    localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);

    state_t           r_state;
    logic [3:0]       r_vec;
    logic [3:0]       r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err;
    logic [3:0]       r_ffv;
    logic             r_ffvld;

    logic             w_exp;
    logic             w_mismatch;
    logic [ERR_W-1:0] w_err_next;

    // Golden response for the vector currently on a..d. Both rails are
    // checked independently so a broken complement output is also caught.
    assign w_exp      = (r_vec[3] & r_vec[2]) | (r_vec[1] & r_vec[0]);
    assign w_mismatch = (out_in ^ w_exp) | (out_n_in ^ ~w_exp);
    assign w_err_next = (w_mismatch && (r_err != ERR_MAX)) ? (r_err + ERR_ONE) : r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_vec   <= 4'd0;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_ffv   <= 4'd0;
            r_ffvld <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_vec   <= 4'd0;
                        r_cnt   <= 4'd0;
                        r_err   <= '0;
                        r_pass  <= 1'b0;
                        r_ffv   <= 4'd0;
                        r_ffvld <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == SETTLE_LAST) begin
                        r_state <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    r_err <= w_err_next;
                    if (w_mismatch && !r_ffvld) begin
                        r_ffv   <= r_vec;
                        r_ffvld <= 1'b1;
                    end
`ifdef AOI_SWEEP_STOP_ON_FAIL_EN
                    // Abort on the first failure; a..d stay on the bad vector.
                    if (w_mismatch || (r_vec == 4'hF)) begin
`else
                    if (r_vec == 4'hF) begin
`endif
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                        r_state <= S_DONE;
                    end else begin
                        r_vec   <= r_vec + 4'd1;
                        r_cnt   <= 4'd0;
                        r_state <= S_SETTLE;
                    end
                end

                S_DONE: begin
                    // Results and last vector are held until the next start.
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign a                = r_vec[3];
    assign b                = r_vec[2];
    assign c                = r_vec[1];
    assign d                = r_vec[0];
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err;
    assign first_fail_vec   = r_ffv;
    assign first_fail_valid = r_ffvld;

endmodule

// File: doc/aoi_sweep_ctrl.md
Name: aoi_sweep_ctrl

Overview:
Self-test sequencer for the 4-input AND-OR gate block (out = (a&b)|(c&d), out_n = ~out). On a start pulse it drives all 16 input vectors in ascending order and waits a programmable settle time per vector. It then checks the sampled out/out_n against the golden function and reports pass/fail, a mismatch count and the first failing vector. It sits between the bench or BIST top and one instance of the gate block.

Parameters:
SETTLE_CYCLES, 1, cycles each vector is held before sampling; legal range 1..15.
ERR_W, 5, width of err_count; saturates at 2^ERR_W-1.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a sweep; sampled only in IDLE
out_in  input  1  out from the gate block
out_n_in  input  1  out_n from the gate block
a  output  1  vector bit 3, registered
b  output  1  vector bit 2, registered
c  output  1  vector bit 1, registered
d  output  1  vector bit 0, registered
busy  output  1  high in SETTLE/CHECK
done  output  1  one-cycle pulse at sweep end
pass  output  1  1 = sweep ended with err_count==0
err_count  output  ERR_W  mismatching vectors in the last sweep
first_fail_vec  output  4  {a,b,c,d} of the first mismatch
first_fail_valid  output  1  first_fail_vec holds a real vector

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset clears: state=IDLE; a,b,c,d=0; busy=0; done=0; pass=0; err_count=0; first_fail_vec=0; first_fail_valid=0. This takes effect immediately, including mid-sweep. No partial results are kept.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE, start=1 at an edge: vec=0 (driven on a..d), settle counter=0, err_count=0, pass=0, first_fail_valid=0, first_fail_vec=0, go to SETTLE.
- SETTLE: counter increments each cycle. After SETTLE_CYCLES cycles, go to CHECK.
- CHECK (one cycle): at the exit edge, sample out_in/out_n_in.
  - Golden values: exp = (a&b)|(c&d); mismatch = (out_in!=exp) | (out_n_in!=~exp).
  - On a mismatch: err_count increments (saturating). If first_fail_valid=0, capture vec and set first_fail_valid=1.
  - If vec==15, go to DONE. Otherwise vec+1, counter=0, go to SETTLE. vec never wraps within a sweep.
- DONE (one cycle): done=1, busy=0, pass=(err_count==0). Return to IDLE.
- After returning to IDLE, a..d hold the last vector (4'hF). pass, err_count and first_fail_* hold until the next accepted start.
- Timing: each vector occupies SETTLE_CYCLES+1 cycles. done is high in cycle 16*(SETTLE_CYCLES+1) after the start-accepting edge (32 for the default).
- start while busy or in DONE is ignored; no queuing.
- An X/Z on out_in counts as a mismatch. Use the !== style compare only in simulation assertions. RTL compares 2-state.

Optional Feature:
AOI_SWEEP_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK goes straight to DONE, with err_count=1, pass=0 and first_fail_* captured. Remaining vectors are skipped and a..d hold the failing vector.
- Undefined: the full 16-vector sweep always runs, as described above.

Test Plan:
1. Correct gate block attached, SETTLE_CYCLES=1, one-cycle start -> busy=1 for 32 cycles, done pulse in cycle 32, pass=1, err_count=0, first_fail_valid=0, a..d=4'hF.
2. out_in stuck at 0, out_n_in=~out_in -> err_count=7, pass=0, first_fail_vec=4'b0011, first_fail_valid=1.
3. out_n_in tied to out_in -> all 16 vectors mismatch: err_count=16, first_fail_vec=4'b0000, pass=0.
4. Second start pulse at cycle 10 of a sweep -> ignored: exactly one done, at cycle 32; results match scenario 1.
5. rst_n low during vector 5 (vec=4'b0101) -> a..d, busy and err_count go 0 asynchronously. A new start restarts at vec 0 and completes normally.
6. With AOI_SWEEP_STOP_ON_FAIL_EN and out_in stuck at 0 -> done after the vector 3 check (cycle 8 for SETTLE_CYCLES=1), err_count=1, first_fail_vec=4'b0011, a..d=4'b0011.
